bit_counter_out_stage: RTL and testbench

BIT_COUNTER_OUT_STAGE -- requirements
Module: bit_counter_out_stage

---
 rtl/bit_counter_pkg.sv | 24 ++
 rtl/bit_counter_fifo_mem.sv | 62 ++++++
 rtl/bit_counter_out_stage.sv | 161 ++++++++++++++++
 tb/tb_bit_counter_out_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bit_counter_pkg.sv
// -----------------------------------------------------------------------------
// bit_counter_pkg
// Shared definitions for the bit-counter output stage.
//   bc_count_w()      : width of a population count for a data word of a given
//                       width ($clog2(width) + 1, so that an all-ones word fits).
//   BC_DEFAULT_WIDTH  : data width of the upstream pipeline in its default build.
//   bc_entry_t        : FIFO entry {data, count} at the default width. Blocks
//                       built with another WIDTH declare the same layout locally
//                       and pass it to the storage as a type parameter.
// -----------------------------------------------------------------------------
package bit_counter_pkg;

  localparam int unsigned BC_DEFAULT_WIDTH = 16;

  function automatic int unsigned bc_count_w(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

  typedef struct packed {
    logic [BC_DEFAULT_WIDTH-1:0]             data;
    logic [bc_count_w(BC_DEFAULT_WIDTH)-1:0] count;
  } bc_entry_t;

endpackage

// File: rtl/bit_counter_fifo_mem.sv
// -----------------------------------------------------------------------------
// bit_counter_fifo_mem
// Circular storage plus read/write pointers for the output-stage FIFO.
// Flags and occupancy are tracked by the caller; this block only stores and
// advances pointers on the strobes it is given.
//
// Parameters
//   DEPTH    : number of entries, power of two, >= 2
//   entry_t  : packed entry type stored per slot
// Ports
//   clk_i    : clock, rising edge
//   arst_n_i : asynchronous active-low reset (pointers only)
//   wr_i     : store wdata_i at the write pointer and advance it
//   wdata_i  : entry to store
//   rd_i     : advance the read pointer
//   rdata_o  : entry at the read pointer (registered storage, no extra stage)
// -----------------------------------------------------------------------------
module bit_counter_fifo_mem
  import bit_counter_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = bc_entry_t
) (
  input  logic   clk_i,
  input  logic   arst_n_i,
  input  logic   wr_i,
  input  entry_t wdata_i,
  input  logic   rd_i,
  output entry_t rdata_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  entry_t          r_mem [DEPTH];
  logic   [PW-1:0] r_wptr;
  logic   [PW-1:0] r_rptr;

  // Storage is deliberately not reset; only the pointers define what is live.
  always_ff @(posedge clk_i) begin
    if (wr_i) begin
      r_mem[r_wptr] <= wdata_i;
    end
  end

  // DEPTH is a power of two, so natural overflow of the pointer wraps mod DEPTH.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (wr_i) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (rd_i) begin
        r_rptr <= r_rptr + PW'(1);
      end
    end
  end

  assign rdata_o = r_mem[r_rptr];

endmodule

// File: rtl/bit_counter_out_stage.sv
// -----------------------------------------------------------------------------
// bit_counter_out_stage
// Output FIFO at the end of the bit-counter pipeline. The pipeline cannot be
// stalled, so the source is throttled ahead of time through src_ready_o with
// enough headroom for the PIPE_LAT words already in flight.
//
// Parameters
//   WIDTH    : data word width (matches the upstream pipeline)
//   DEPTH    : FIFO entries, power of two, >= 2
//   PIPE_LAT : pipeline stages between source and this block, < DEPTH
// Ports
//   clk_i        : clock, rising edge
//   arst_n_i     : asynchronous active-low reset
//   data_i       : word from the last pipeline stage
//   data_val_i   : data_i/count_i valid (no backpressure possible)
//   count_i      : population count of data_i
//   src_ready_o  : source may issue a new word
//   data_o       : head-of-FIFO word
//   count_o      : head-of-FIFO count
//   data_val_o   : head entry valid
//   data_ready_i : consumer accepts head entry
//   level_o      : number of stored entries
//   overflow_o   : sticky, a word was dropped because the FIFO was full
//   delivered_o  : number of entries read (0 unless stats enabled)
//
// Build option
//   BIT_COUNTER_OUT_STATS_EN : when defined, delivered_o counts reads (wraps at
//                              2^32); otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module bit_counter_out_stage
  import bit_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic                     clk_i,
  input  logic                     arst_n_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     data_val_i,
  input  logic [$clog2(WIDTH):0]   count_i,
  output logic                     src_ready_o,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(WIDTH):0]   count_o,
  output logic                     data_val_o,
  input  logic                     data_ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
  output logic [31:0]              delivered_o
);

  localparam int unsigned CW = bc_count_w(WIDTH);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  localparam logic [LW-1:0] DepthL   = LW'(DEPTH);
  localparam logic [LW-1:0] PipeLatL = LW'(PIPE_LAT);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [CW-1:0]    count;
  } entry_t;

  logic [LW-1:0] r_level;
  logic [LW-1:0] w_level_d;
  logic          r_overflow;
  logic          w_full;
  logic          w_wr;
  logic          w_rd;
  logic          w_drop;
  entry_t        w_wentry;
  entry_t        w_head;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  assign data_val_o = (r_level != '0);
  assign w_full     = (r_level == DepthL);
  assign w_rd       = data_val_o & data_ready_i;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  // An empty FIFO never bypasses: the word lands in storage first.
  assign w_wr       = data_val_i & (~w_full | w_rd);
  assign w_drop     = data_val_i & w_full & ~w_rd;

  // Headroom must cover every word already inside the pipeline.
  assign src_ready_o = (DepthL - r_level) > PipeLatL;

  // ---------------------------------------------------------------------------
  // Occupancy
  // ---------------------------------------------------------------------------
  always_comb begin
    w_level_d = r_level;
    unique case ({w_wr, w_rd})
      2'b10:   w_level_d = r_level + LW'(1);
      2'b01:   w_level_d = r_level - LW'(1);
      default: w_level_d = r_level;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_level <= '0;
    end else begin
      r_level <= w_level_d;
    end
  end

  assign level_o = r_level;

  // ---------------------------------------------------------------------------
  // Sticky overflow
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow_o = r_overflow;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  assign w_wentry = '{data: data_i, count: count_i};

  bit_counter_fifo_mem #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_mem (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .wr_i     (w_wr),
    .wdata_i  (w_wentry),
    .rd_i     (w_rd),
    .rdata_o  (w_head)
  );

  assign data_o  = w_head.data;
  assign count_o = w_head.count;

  // ---------------------------------------------------------------------------
  // Delivery statistics
  // ---------------------------------------------------------------------------
`ifdef BIT_COUNTER_OUT_STATS_EN
  logic [31:0] r_delivered;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_delivered <= '0;
    end else if (w_rd) begin
      r_delivered <= r_delivered + 32'd1;
    end
  end

  assign delivered_o = r_delivered;
`else
  assign delivered_o = '0;
`endif

endmodule

// File: tb/tb_bit_counter_out_stage.sv
module tb_bit_counter_out_stage;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned PIPE_LAT = 2;
  localparam int unsigned CW       = $clog2(WIDTH) + 1;
  localparam int unsigned LW       = $clog2(DEPTH) + 1;

  logic             clk_i = 1'b0;
  logic             arst_n_i = 1'b0;
  logic [WIDTH-1:0] data_i = '0;
  logic             data_val_i = 1'b0;
  logic [CW-1:0]    count_i = '0;
  logic             src_ready_o;
  logic [WIDTH-1:0] data_o;
  logic [CW-1:0]    count_o;
  logic             data_val_o;
  logic             data_ready_i = 1'b0;
  logic [LW-1:0]    level_o;
  logic             overflow_o;
  logic [31:0]      delivered_o;

  bit_counter_out_stage #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .clk_i        (clk_i),
    .arst_n_i     (arst_n_i),
    .data_i       (data_i),
    .data_val_i   (data_val_i),
    .count_i      (count_i),
    .src_ready_o  (src_ready_o),
    .data_o       (data_o),
    .count_o      (count_o),
    .data_val_o   (data_val_o),
    .data_ready_i (data_ready_i),
    .level_o      (level_o),
    .overflow_o   (overflow_o),
    .delivered_o  (delivered_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a queue of words with the accept/drop rules applied per edge
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] m_q[$];
  bit               m_ovf;
  int unsigned      m_deliv;
  bit               m_rd;
  bit               m_wr;

  always @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      m_q.delete();
      m_ovf   = 1'b0;
      m_deliv = 0;
    end else begin
      m_rd = (m_q.size() != 0) && data_ready_i;
      m_wr = data_val_i && ((m_q.size() < DEPTH) || m_rd);
      if (m_rd) begin
        void'(m_q.pop_front());
        m_deliv++;
      end
      if (m_wr) m_q.push_back(data_i);
      else if (data_val_i) m_ovf = 1'b1;
    end
  end

  // Per-cycle comparison against the model on the falling edge
  bit run_cmp = 1'b1;
  int unsigned exp_deliv;

  always @(negedge clk_i) begin
    if (run_cmp) begin
`ifdef BIT_COUNTER_OUT_STATS_EN
      exp_deliv = m_deliv;
`else
      exp_deliv = 0;
`endif
      chk("level", 64'(level_o), 64'(m_q.size()));
      chk("data_val", 64'(data_val_o), 64'(m_q.size() != 0));
      chk("src_ready", 64'(src_ready_o), 64'((DEPTH - m_q.size()) > PIPE_LAT));
      chk("overflow", 64'(overflow_o), 64'(m_ovf));
      chk("delivered", 64'(delivered_o), 64'(exp_deliv));
      if (m_q.size() != 0) begin
        chk("head_data", 64'(data_o), 64'(m_q[0]));
        chk("head_count", 64'(count_o), 64'($countones(m_q[0])));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] popped[$];

  // Drive one cycle of inputs; record the head if it is consumed this cycle.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic rdy);
    data_val_i   = v;
    data_i       = d;
    count_i      = CW'($countones(d));
    data_ready_i = rdy;
    if (data_val_o && rdy) popped.push_back(data_o);
    @(posedge clk_i);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk_i);
    #1 arst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_level", 64'(level_o), 64'd0);
    chk("rst_val", 64'(data_val_o), 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    chk("rst_deliv", 64'(delivered_o), 64'd0);
    chk("rst_src_ready", 64'(src_ready_o), 64'd1);
    release_reset();

    // First word, consumer stalled
    step(1'b1, 16'h00FF, 1'b0);
    chk("w1_val", 64'(data_val_o), 64'd1);
    chk("w1_data", 64'(data_o), 64'h00FF);
    chk("w1_count", 64'(count_o), 64'd8);
    chk("w1_level", 64'(level_o), 64'd1);
    chk("lvl1_src_ready", 64'(src_ready_o), 64'd1);

    // src_ready threshold
    step(1'b1, 16'h1234, 1'b0);
    chk("lvl2_src_ready", 64'(src_ready_o), 64'd0);
    step(1'b1, 16'h0F0F, 1'b0);
    chk("lvl3_src_ready", 64'(src_ready_o), 64'd0);

    // Fill, then overflow with no read
    step(1'b1, 16'h8001, 1'b0);
    chk("full_level", 64'(level_o), 64'd4);
    chk("full_ovf", 64'(overflow_o), 64'd0);
    step(1'b1, 16'hDEAD, 1'b0);
    chk("drop_level", 64'(level_o), 64'd4);
    chk("drop_ovf", 64'(overflow_o), 64'd1);
    chk("drop_head", 64'(data_o), 64'h00FF);

    // Write while reading at full
    popped.delete();
    step(1'b1, 16'hAAAA, 1'b1);
    chk("fullrw_level", 64'(level_o), 64'd4);
    chk("fullrw_pop", 64'(popped[0]), 64'h00FF);
    popped.delete();
    repeat (4) step(1'b0, 16'h0000, 1'b1);
    chk("drain_n", 64'(popped.size()), 64'd4);
    chk("drain_1st", 64'(popped[0]), 64'h1234);
    chk("drain_4th", 64'(popped[3]), 64'hAAAA);
    chk("drain_level", 64'(level_o), 64'd0);
    chk("drain_ovf_sticky", 64'(overflow_o), 64'd1);

    // Reset clears the sticky flag
    arst_n_i = 1'b0;
    #1;
    chk("rst2_ovf", 64'(overflow_o), 64'd0);
    release_reset();

    // Streaming through, pointers wrap
    popped.delete();
    for (int i = 1; i <= 10; i++) step(1'b1, WIDTH'(i), 1'b1);
    step(1'b0, 16'h0000, 1'b1);
    chk("stream_n", 64'(popped.size()), 64'd10);
    for (int i = 0; i < 10; i++) chk("stream_order", 64'(popped[i]), 64'(i + 1));
    chk("stream_level", 64'(level_o), 64'd0);
    chk("stream_ovf", 64'(overflow_o), 64'd0);
`ifdef BIT_COUNTER_OUT_STATS_EN
    chk("stream_deliv", 64'(delivered_o), 64'd10);
`else
    chk("stream_deliv", 64'(delivered_o), 64'd0);
`endif

    // Mid-burst reset at level 3 with overflow set
    repeat (4) step(1'b1, 16'h0011, 1'b0);
    step(1'b1, 16'h0055, 1'b0);
    step(1'b0, 16'h0000, 1'b1);
    chk("pre_rst_level", 64'(level_o), 64'd3);
    chk("pre_rst_ovf", 64'(overflow_o), 64'd1);
    data_val_i = 1'b0;
    data_ready_i = 1'b0;
    #2 arst_n_i = 1'b0;
    #1;
    chk("midrst_val", 64'(data_val_o), 64'd0);
    chk("midrst_level", 64'(level_o), 64'd0);
    chk("midrst_ovf", 64'(overflow_o), 64'd0);
    chk("midrst_deliv", 64'(delivered_o), 64'd0);
    release_reset();

    // First write after release lands on its own
    step(1'b1, 16'h0C03, 1'b0);
    chk("post_level", 64'(level_o), 64'd1);
    chk("post_data", 64'(data_o), 64'h0C03);
    chk("post_count", 64'(count_o), 64'd4);
    step(1'b0, 16'h0000, 1'b0);

    run_cmp = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
